// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (iterative shift-and-add-3) feeding a 3-digit multiplexed
// common-anode 7-segment scan. Optional leading-zero blanking: define LZ_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for sample; scan shows last bcd
// CONV  | one add-3/shift iteration per clock, 8 total
// DONE  | publish scratch to bcd, pulse valid
module bcd_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          REVERSE_IN  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  bin_in,
  input  logic        sample,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;

  logic [7:0]    bin_ord;
  logic [11:0]   scratch_adj;
  logic [19:0]   shifted;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bin_ord[i] = REVERSE_IN ? bin_in[7-i] : bin_in[i];
    end
  end

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      scratch_adj[n*4 +: 4] = (scratch_q[n*4 +: 4] >= 4'd5) ? scratch_q[n*4 +: 4] + 4'd3
                                                            : scratch_q[n*4 +: 4];
    end
    shifted = {scratch_adj, shreg_q} << 1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample) begin
          shreg_d   = bin_ord;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_d = shifted[19:8];
        shreg_d   = shifted[7:0];
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = valid_q;
  assign bcd   = bcd_q;

  // Display scan runs free of the converter FSM.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [3:0] nib_sel;
  logic       blank;

  always_comb begin
    nib_sel = '0;
    an      = 3'b111;
    case (digit_q)
      2'd0: begin nib_sel = bcd_q[3:0];  an = 3'b110; end
      2'd1: begin nib_sel = bcd_q[7:4];  an = 3'b101; end
      2'd2: begin nib_sel = bcd_q[11:8]; an = 3'b011; end
      default: begin nib_sel = '0; an = 3'b111; end
    endcase
  end

`ifdef LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    if (digit_q == 2'd2) begin
      blank = (bcd_q[11:8] == 4'd0);
    end else if (digit_q == 2'd1) begin
      blank = (bcd_q[11:4] == 8'd0);
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg = blank ? 7'b1111111 : seg_decode(nib_sel);

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: two instances (REVERSE_IN=1 and 0),
// REFRESH_DIV=4, arithmetic reference model for conversion and scan.
module tb_bcd_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  bin_r = '0, bin_f = '0;
  logic        smp_r = 1'b0, smp_f = 1'b0;
  logic        busy_r, busy_f, valid_r, valid_f;
  logic [11:0] bcd_r, bcd_f;
  logic [6:0]  seg_r, seg_f;
  logic [2:0]  an_r, an_f;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  logic [11:0] mdl_r = '0, mdl_f = '0;

  always #5 clk = ~clk;

  bcd_display_driver #(.REFRESH_DIV(RD), .REVERSE_IN(1'b1)) u_rev (
    .clk(clk), .clr(clr), .bin_in(bin_r), .sample(smp_r),
    .busy(busy_r), .valid(valid_r), .bcd(bcd_r), .seg(seg_r), .an(an_r));

  bcd_display_driver #(.REFRESH_DIV(RD), .REVERSE_IN(1'b0)) u_fwd (
    .clk(clk), .clr(clr), .bin_in(bin_f), .sample(smp_f),
    .busy(busy_f), .valid(valid_f), .bcd(bcd_f), .seg(seg_f), .an(an_f));

  // Clocks elapsed since reset release: drives the scan model.
  always @(posedge clk or negedge clr) begin
    if (!clr) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  function automatic logic [11:0] exp_bcd(input logic [7:0] raw, input bit rev);
    int v;
    v = rev ? int'(rev8(raw)) : int'(raw);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input bit which);
    int d, val, h, t;
    logic [6:0] es;
    logic [11:0] m;
    m   = which ? mdl_r : mdl_f;
    val = int'(m[11:8]) * 100 + int'(m[7:4]) * 10 + int'(m[3:0]);
    d   = (edges / RD) % 3;
    h   = val / 100;
    t   = (val / 10) % 10;
    es  = (d == 0) ? seg_of(val % 10) : (d == 1) ? seg_of(t) : seg_of(h);
`ifdef LZ_BLANK_EN
    if ((d == 2 && h == 0) || (d == 1 && val < 10)) es = 7'b1111111;
`endif
    check(which ? "an_rev" : "an_fwd", {29'd0, which ? an_r : an_f}, {29'd0, ~(3'b001 << d)});
    check(which ? "seg_rev" : "seg_fwd", {25'd0, which ? seg_r : seg_f}, {25'd0, es});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input bit which, input logic [7:0] raw);
    logic [11:0] e;
    e = exp_bcd(raw, which);
    if (which) begin bin_r = raw; smp_r = 1'b1; end
    else       begin bin_f = raw; smp_f = 1'b1; end
    tick();
    smp_r = 1'b0; smp_f = 1'b0;
    bin_r = 8'($urandom); bin_f = 8'($urandom);
    for (int k = 0; k < 9; k++) begin
      check("busy_conv", {31'd0, which ? busy_r : busy_f}, 32'd1);
      check("valid_early", {31'd0, which ? valid_r : valid_f}, 32'd0);
      if (k < 8) tick();
      else @(posedge clk);
    end
    #1;
    if (which) mdl_r = e; else mdl_f = e;
    check("busy_done", {31'd0, which ? busy_r : busy_f}, 32'd0);
    check("valid_pulse", {31'd0, which ? valid_r : valid_f}, 32'd1);
    check("bcd_result", {20'd0, which ? bcd_r : bcd_f}, {20'd0, e});
    check_disp(which);
    tick();
    check("valid_one", {31'd0, which ? valid_r : valid_f}, 32'd0);
    check("bcd_hold", {20'd0, which ? bcd_r : bcd_f}, {20'd0, e});
  endtask

  initial begin
    int nvalid;

    // 1. Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      bin_r = 8'($urandom); bin_f = 8'($urandom);
      smp_r = 1'($urandom); smp_f = 1'($urandom);
      tick();
    end
    check("rst_bcd", {20'd0, bcd_r}, 32'd0);
    check("rst_busy", {31'd0, busy_r}, 32'd0);
    check("rst_valid", {31'd0, valid_f}, 32'd0);
    check("rst_an", {29'd0, an_r}, 32'b110);
    check("rst_seg", {25'd0, seg_r}, 32'b1000000);
    smp_r = 1'b0; smp_f = 1'b0;
    #2 clr = 1'b1;
    tick();

    // 2 and 3. Directed values and bit order.
    run_conv(1'b1, 8'hFF);
    run_conv(1'b1, 8'b0000_0001);
    run_conv(1'b1, 8'b1000_0000);
    run_conv(1'b0, 8'b0000_0001);
    run_conv(1'b0, 8'd99);
    run_conv(1'b0, 8'd0);
    run_conv(1'b0, 8'd255);

    // 4. Second sample while busy is dropped.
    bin_f = 8'h0F; smp_f = 1'b1;
    tick();
    smp_f = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin bin_f = 8'h64; smp_f = 1'b1; end
      if (k == 4) smp_f = 1'b0;
      tick();
      if (valid_f) nvalid++;
    end
    mdl_f = 12'h015;
    check("busy_ignore_cnt", nvalid, 32'd1);
    check("busy_ignore_bcd", {20'd0, bcd_f}, 32'h015);

    // 5. Scan over several digit slots with bcd=042.
    run_conv(1'b1, rev8(8'd42));
    for (int k = 0; k < 14; k++) begin
      check_disp(1'b1);
      check_disp(1'b0);
      tick();
    end

    // Randomized conversions on both instances.
    for (int k = 0; k < 10; k++) begin
      run_conv(k[0], 8'($urandom));
    end

    // 6. Async reset mid-conversion of 200.
    bin_r = rev8(8'd200); smp_r = 1'b1;
    tick();
    smp_r = 1'b0;
    repeat (4) tick();
    #3 clr = 1'b0;
    #1;
    mdl_r = '0; mdl_f = '0;
    check("abort_busy", {31'd0, busy_r}, 32'd0);
    check("abort_bcd", {20'd0, bcd_r}, 32'd0);
    check("abort_an", {29'd0, an_r}, 32'b110);
    check("abort_seg", {25'd0, seg_r}, 32'b1000000);
    #2 clr = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (valid_r || busy_r) nvalid++;
    end
    check("abort_novalid", nvalid, 32'd0);
    check("abort_bcd_hold", {20'd0, bcd_r}, 32'd0);
    check_disp(1'b1);
    run_conv(1'b1, rev8(8'd200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Downstream consumer of the 8-bit toggle-flip-flop counter stage. Converts the counter value to 3-digit BCD with an iterative shift-and-add-3 engine.
- Drives a 3-digit multiplexed common-anode 7-segment display.
- Conversion runs on demand via a sample strobe. The display scan runs continuously from the last converted result.

Parameters:
- REFRESH_DIV, 50000, clocks per digit slot of the scan; legal range 2..2^20.
- REVERSE_IN, 1, 1 = bin_in[7] is the LSB and bin_in[0] is the MSB (counter-stage bit order); 0 = conventional order with bin_in[7] as the MSB.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- bin_in  in  8  binary value to convert; bit order set by REVERSE_IN
- sample  in  1  conversion request; level sampled each clock
- busy  out  1  conversion in progress; sample ignored while high
- valid  out  1  one-cycle pulse when bcd updates
- bcd  out  12  {hundreds, tens, ones} nibbles of the last completed conversion
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  3  digit enables, active-low; an[0] = ones, an[2] = hundreds

Behaviour:
- Reset (clr=0, asynchronous, dominant over everything):
  - state=IDLE, busy=0, valid=0, bcd=12'h000.
  - Refresh counter=0, digit index=0.
  - an=3'b110, seg=7'b1000000 (displays "0").
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - sample=1 at edge E0: capture bin_in into the shift register (bit-reversed if REVERSE_IN=1).
  - Clear the 12-bit scratch register and the iteration counter.
  - Go to CONV; busy=1 from E0.
- CONV, one iteration per clock at E1..E8:
  - Add 3 to each scratch nibble whose value is >=5.
  - Then shift {scratch, shreg} left by 1.
  - After the 8th shift (E8), go to DONE.
- DONE (edge E9):
  - Copy scratch to bcd, pulse valid=1 for the cycle after E9.
  - busy=0 after E9; return to IDLE.
- Latency: sample-accept edge to valid high is 9 clocks. Minimum sample-to-sample spacing is 10 clocks.
- sample while busy=1 (CONV or DONE): ignored, not queued.
- bin_in changes after E0 do not affect the conversion in progress.
- bcd holds its value between conversions. It changes only at DONE.
- Range: input 0..255 maps to BCD 000..255. Hundreds nibble is <=2. Tens and ones nibbles are always <=9.
- Scan, running continuously and independent of the FSM:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index advances 0→1→2→0.
  - an is the active-low one-hot of the digit index.
  - seg is the decode of the selected bcd nibble.
- Decode (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble = 1111111 (blank); this cannot occur in normal use.
- seg and an are combinational from registered bcd and digit index. When bcd updates, the new value appears on the currently selected digit in the same cycle.
- Reset mid-conversion: the conversion is aborted. No valid pulse occurs after clr releases, and bcd=000.

Optional Feature:
- Macro LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Hundreds digit is blanked (seg=1111111, an still scans) when the hundreds nibble is 0.
  - Tens digit is blanked when both the hundreds and tens nibbles are 0.
  - Ones digit is never blanked.
  - The reset display is unchanged ("0" on the ones digit).
- Undefined: all three digits are always shown, e.g. "007".

Test Plan:
1. Reset: hold clr=0 with random inputs → bcd=000, busy=0, valid=0, an=110, seg=1000000. Assert clr asynchronously mid-cycle → outputs reach reset values before the next edge.
2. REVERSE_IN=1, bin_in=8'hFF, sample pulse at E0 → busy high E0..E9, valid high for exactly the one cycle after E9, bcd=12'h255.
3. Bit order with REVERSE_IN=1: bin_in=8'b0000_0001 → bcd=128; bin_in=8'b1000_0000 → bcd=001. With REVERSE_IN=0: bin_in=8'b0000_0001 → bcd=001; bin_in=8'd99 → bcd=099.
4. Sample ignored while busy: sample at E0 with 8'h0F (REVERSE_IN=0), second sample at E3 with 8'h64 → one valid only, bcd=015.
5. Scan with REFRESH_DIV=4 and bcd=042: an steps 110→101→011 every 4 clocks, seg shows 2, 4, 0. With LZ_BLANK_EN, the hundreds slot shows 1111111.
6. clr low at E4 of a conversion of 200, then released → busy=0 immediately, no valid pulse, bcd=000. A new sample then yields 200 after 9 clocks.
